uart_receive: RTL
=================

Name: uart_receive

Overview:
- UART 8N1 receiver; the receive-side counterpart of the team's uart_transmit. Frame: start bit, 8 data bits LSB first, stop bit.
- Samples an asynchronous serial line at mid-bit and presents each byte with a one-cycle valid strobe.
- Sits between the board RX pin and the host-command parser.

Parameters:
- INPUT_CLOCK_FREQ, 100_000_000, clk frequency in Hz.
- BAUD_RATE, 9600, line rate in bit/s.
- Derived: CLOCKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE; HALF_BIT = CLOCKS_PER_BIT / 2.
- Counter width = $clog2(CLOCKS_PER_BIT).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- din  input  1  serial line, asynchronous to clk, idle high.
- dout  output  8  last received byte; holds its value until the next good frame.
- valid  output  1  one-cycle pulse; dout is new in this same cycle.
- busy  output  1  high while a frame is in progress.
- framing_error  output  1  one-cycle pulse when the stop bit samples low.
- parity_error  output  1  one-cycle pulse; see Optional Feature.

Behaviour:
- Reset (asynchronous, active-high): dout=8'h00, valid=0, busy=0, framing_error=0, parity_error=0, state=IDLE, both synchronizer flops=1, all counters=0.
- Synchronizer: din passes through a 2-flop synchronizer before any use. Only the synchronized signal rx_s drives logic.
- IDLE:
  - rx_s==0 -> go to START, clock_counter=0, busy=1 in the next cycle.
- START:
  - When clock_counter==HALF_BIT-1, sample rx_s.
  - Sample 0 -> go to DATA, clock_counter=0, bit_counter=0.
  - Sample 1 -> glitch. Go to IDLE, busy=0, no output pulses.
- DATA:
  - When clock_counter==CLOCKS_PER_BIT-1, sample rx_s into shift_reg[7] and shift right (LSB first), then bit_counter+1.
  - After the 8th sample -> go to STOP (or PARITY if the feature is enabled).
- STOP:
  - When clock_counter==CLOCKS_PER_BIT-1, sample rx_s.
  - Sample 1 -> next cycle: dout=shift_reg, valid=1.
  - Sample 0 -> next cycle: framing_error=1, dout unchanged, valid stays 0.
  - In both cases go to IDLE, busy=0 in that same cycle.
- Early return: IDLE is re-entered at the middle of the stop bit, so back-to-back frames with no idle gap are received.
- Latency: valid rises exactly 1 + 9*CLOCKS_PER_BIT + HALF_BIT cycles after the first cycle rx_s==0 (N8 mode).
- Pulses: valid, framing_error and parity_error are never high for more than one cycle.
- Line held low (break): produces framing_error. The block then waits in IDLE and treats the continuing low as a new start bit. The resulting repeated framing_error pulses are accepted behaviour.
- Reset mid-frame: the partial byte is discarded and dout keeps its reset value.
- Counters saturate nowhere. Every compare is an equality test against constants derived from the parameters.

Optional Feature:
- Macro: UART_RECEIVE_PARITY_EN.
- Defined:
  - The frame carries an even-parity bit after D7: a PARITY state sampled at mid-bit, then STOP.
  - Parity mismatch with a good stop bit -> parity_error pulse, dout is still updated, valid=1 in the same cycle.
  - Stop bit low -> framing_error only.
  - Latency grows by CLOCKS_PER_BIT.
- Not defined:
  - No PARITY state; 8N1 only.
  - parity_error is tied to 0.

Test Plan (INPUT_CLOCK_FREQ=1_000_000, BAUD_RATE=100_000, so CLOCKS_PER_BIT=10, HALF_BIT=5):
- Reset held, then released with din=1 -> all outputs 0, dout=8'h00, busy=0 for 200 cycles.
- Send 8'hA5 with 10-cycle bits -> one valid pulse, dout=8'hA5, framing_error=0, valid 1+95 cycles after rx_s falls.
- Send 8'h3C then 8'h81 back-to-back with no idle gap -> two valid pulses 100 cycles apart, dout=8'h3C then 8'h81.
- Drive din low for 3 cycles, then high -> busy pulses briefly, no valid, no framing_error, block returns to IDLE.
- Send 8'h55 with the stop bit driven 0 -> framing_error pulse, valid=0, dout keeps its previous value.
- Assert rst at data bit 4 of 8'hFF, release it, then send 8'h12 -> outputs reset immediately, next valid gives dout=8'h12.
- With UART_RECEIVE_PARITY_EN, send 8'h07 with parity bit 0 (wrong; correct is 1) -> valid=1, dout=8'h07, parity_error=1 in the same cycle.

Source files
------------

// File: rtl/uart_receive.sv
// rtl/uart_receive.sv - UART 8N1 receiver, mid-bit sampling; UART_RECEIVE_PARITY_EN adds even parity
module uart_receive #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       din,
    output logic [7:0] dout,
    output logic       valid,
    output logic       busy,
    output logic       framing_error,
    output logic       parity_error
);

    localparam int CLOCKS_PER_BIT = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT       = CLOCKS_PER_BIT / 2;
    localparam int CNT_W          = $clog2(CLOCKS_PER_BIT);

    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state;
    state_t           state_next;
    logic             rx_meta;
    logic             rx_s;
    logic [CNT_W-1:0] clock_counter;
    logic [2:0]       bit_counter;
    logic [7:0]       shift_reg;

    logic half_hit;
    logic full_hit;
    logic count_clear;
    logic shift_en;
    logic stop_good;
    logic stop_bad;
`ifdef UART_RECEIVE_PARITY_EN
    logic parity_en;
    logic parity_mismatch;
`endif

    assign half_hit = (clock_counter == HALF_LAST);
    assign full_hit = (clock_counter == FULL_LAST);
    assign busy     = (state != S_IDLE);

    // Two-flop synchronizer; idle-high line so both stages reset to 1.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= din;
            rx_s    <= rx_meta;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state: start qualified at mid start bit, stop sampled at mid bit then straight back to idle.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (!rx_s) state_next = S_START;
            end
            S_START: begin
                if (half_hit) state_next = rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (full_hit && (bit_counter == 3'd7)) begin
`ifdef UART_RECEIVE_PARITY_EN
                    state_next = S_PARITY;
`else
                    state_next = S_STOP;
`endif
                end
            end
`ifdef UART_RECEIVE_PARITY_EN
            S_PARITY: begin
                if (full_hit) state_next = S_STOP;
            end
`endif
            S_STOP: begin
                if (full_hit) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Per-state datapath strobes derived from the sample points.
    always_comb begin
        count_clear = 1'b0;
        shift_en    = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
`ifdef UART_RECEIVE_PARITY_EN
        parity_en   = 1'b0;
`endif
        case (state)
            S_IDLE:  count_clear = 1'b1;
            S_START: count_clear = half_hit;
            S_DATA: begin
                count_clear = full_hit;
                shift_en    = full_hit;
            end
`ifdef UART_RECEIVE_PARITY_EN
            S_PARITY: begin
                count_clear = full_hit;
                parity_en   = full_hit;
            end
`endif
            S_STOP: begin
                count_clear = full_hit;
                stop_good   = full_hit && rx_s;
                stop_bad    = full_hit && !rx_s;
            end
            default: count_clear = 1'b1;
        endcase
    end

    // Bit timing, LSB-first shift register and registered one-cycle result pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clock_counter <= '0;
            bit_counter   <= 3'd0;
            shift_reg     <= 8'h00;
            dout          <= 8'h00;
            valid         <= 1'b0;
            framing_error <= 1'b0;
        end else begin
            clock_counter <= count_clear ? '0 : clock_counter + CNT_W'(1);
            valid         <= stop_good;
            framing_error <= stop_bad;
            if (state == S_IDLE) begin
                bit_counter <= 3'd0;
            end
            if (shift_en) begin
                shift_reg   <= {rx_s, shift_reg[7:1]};
                bit_counter <= bit_counter + 3'd1;
            end
            if (stop_good) begin
                dout <= shift_reg;
            end
        end
    end

`ifdef UART_RECEIVE_PARITY_EN
    // Even parity: data XOR parity bit must be 0; reported alongside valid on a good stop bit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            parity_mismatch <= 1'b0;
            parity_error    <= 1'b0;
        end else begin
            if (parity_en) begin
                parity_mismatch <= (^shift_reg) ^ rx_s;
            end
            parity_error <= stop_good && parity_mismatch;
        end
    end
`else
    assign parity_error = 1'b0;
`endif

endmodule
